// File: rtl/d_cache_assoc.sv
// d_cache_assoc: 1/2-way set-associative write-through data cache, 1-word lines.
// Define DCACHE_PERF_EN to add the perf_hit_cnt/perf_miss_cnt counters.
module d_cache_assoc #(
  parameter int INDEX_WIDTH = 6,
  parameter int WAYS        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);

  localparam int SETS = 1 << INDEX_WIDTH;
  localparam int TW   = 30 - INDEX_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MEM_ADDR,
    MEM_DATA
  } state_t;

  state_t state, state_nx;

  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic [TW-1:0]   tag_arr  [WAYS][SETS];
  logic [31:0]     data_arr [WAYS][SETS];
  logic [SETS-1:0] valid    [WAYS];
  logic [SETS-1:0] lru;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TW-1:0]          tag;
  logic                   cached;
  logic                   fill;
  logic [WAYS-1:0]        way_hit;
  logic                   hit;
  logic                   hit_way;
  logic                   victim;
  logic [31:0]            hit_word;
  logic [31:0]            merged;
  logic [3:0]             byte_en;
  logic                   lookup;
  logic                   mem_done;

  assign idx      = req_addr[INDEX_WIDTH+1:2];
  assign tag      = req_addr[31:INDEX_WIDTH+2];
  assign cached   = req_addr[31:29] != 3'b101;
  assign fill     = cached && !req_wr;
  assign lookup   = state == LOOKUP;
  assign mem_done = state == MEM_DATA && cache_data_data_ok;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_hit[w] = valid[w][idx] && tag_arr[w][idx] == tag;
  end

  assign hit      = cached && |way_hit;
  assign hit_way  = (WAYS == 2) ? way_hit[WAYS-1] : 1'b0;
  assign hit_word = data_arr[hit_way][idx];

  // invalid ways fill first (way0 before way1), then the LRU way
  assign victim = (WAYS != 2)          ? 1'b0 :
                  !valid[0][idx]       ? 1'b0 :
                  !valid[WAYS-1][idx]  ? 1'b1 : lru[idx];

  always_comb begin
    unique case (req_size)
      2'd0:    byte_en = 4'b0001 << req_addr[1:0];
      2'd1:    byte_en = req_addr[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
    merged = hit_word;
    for (int b = 0; b < 4; b++)
      if (byte_en[b]) merged[8*b+:8] = req_wdata[8*b+:8];
  end

  always_ff @(posedge clk) begin
    if (lookup && hit && req_wr)
      data_arr[hit_way][idx] <= merged;
    if (mem_done && fill) begin
      tag_arr[victim][idx]  <= tag;
      data_arr[victim][idx] <= cache_data_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_wr    <= 1'b0;
      req_size  <= 2'd0;
      req_addr  <= '0;
      req_wdata <= '0;
      lru       <= '0;
      for (int w = 0; w < WAYS; w++) valid[w] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cpu_data_req) begin
        req_wr    <= cpu_data_wr;
        req_size  <= cpu_data_size;
        req_addr  <= cpu_data_addr;
        req_wdata <= cpu_data_wdata;
      end
      if (lookup && hit)
        lru[idx] <= ~hit_way;
      if (mem_done && fill) begin
        valid[victim][idx] <= 1'b1;
        lru[idx]           <= ~victim;
      end
    end
  end

`ifdef DCACHE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (lookup && cached) begin
      if (hit) perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      else     perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    state_nx         = state;
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;
    cpu_data_rdata   = '0;
    cache_data_req   = 1'b0;
    cache_data_wr    = 1'b0;
    cache_data_size  = 2'd0;
    cache_data_addr  = '0;
    cache_data_wdata = '0;
    unique case (state)
      IDLE: begin
        if (cpu_data_req) begin
          cpu_data_addr_ok = 1'b1;
          state_nx         = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit && !req_wr) begin
          cpu_data_data_ok = 1'b1;
          cpu_data_rdata   = hit_word;
          state_nx         = IDLE;
        end else begin
          state_nx = MEM_ADDR;
        end
      end
      MEM_ADDR: begin
        cache_data_req   = 1'b1;
        cache_data_wr    = req_wr;
        cache_data_size  = fill ? 2'd2 : req_size;
        cache_data_addr  = fill ? {req_addr[31:2], 2'b00} : req_addr;
        cache_data_wdata = req_wdata;
        if (cache_data_addr_ok) state_nx = MEM_DATA;
      end
      MEM_DATA: begin
        if (cache_data_data_ok) begin
          cpu_data_data_ok = 1'b1;
          cpu_data_rdata   = cache_data_rdata;
          state_nx         = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!rst) begin
      state_nx         = IDLE;
      cpu_data_addr_ok = 1'b0;
      cpu_data_data_ok = 1'b0;
      cpu_data_rdata   = '0;
      cache_data_req   = 1'b0;
      cache_data_wr    = 1'b0;
      cache_data_size  = 2'd0;
      cache_data_addr  = '0;
      cache_data_wdata = '0;
    end
  end

endmodule

// File: tb/tb_d_cache_assoc.sv
// tb_d_cache_assoc: random + directed accesses against a recency-list cache
// model and a word memory model, with a randomly stalling memory responder.
module tb_d_cache_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_data_req;
  logic        cpu_data_wr;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr;
  logic [31:0] cpu_data_wdata;
  logic [31:0] cpu_data_rdata;
  logic        cpu_data_addr_ok;
  logic        cpu_data_data_ok;
  logic        cache_data_req;
  logic        cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr;
  logic [31:0] cache_data_wdata;
  logic [31:0] cache_data_rdata;
  logic        cache_data_addr_ok;
  logic        cache_data_data_ok;
`ifdef DCACHE_PERF_EN
  logic [31:0] perf_hit_cnt;
  logic [31:0] perf_miss_cnt;
`endif

  always #5 clk = ~clk;

  d_cache_assoc dut (
    .clk                (clk),
    .rst                (rst),
    .cpu_data_req       (cpu_data_req),
    .cpu_data_wr        (cpu_data_wr),
    .cpu_data_size      (cpu_data_size),
    .cpu_data_addr      (cpu_data_addr),
    .cpu_data_wdata     (cpu_data_wdata),
    .cpu_data_rdata     (cpu_data_rdata),
    .cpu_data_addr_ok   (cpu_data_addr_ok),
    .cpu_data_data_ok   (cpu_data_data_ok),
    .cache_data_req     (cache_data_req),
    .cache_data_wr      (cache_data_wr),
    .cache_data_size    (cache_data_size),
    .cache_data_addr    (cache_data_addr),
    .cache_data_wdata   (cache_data_wdata),
    .cache_data_rdata   (cache_data_rdata),
    .cache_data_addr_ok (cache_data_addr_ok),
    .cache_data_data_ok (cache_data_data_ok)
`ifdef DCACHE_PERF_EN
    ,
    .perf_hit_cnt       (perf_hit_cnt),
    .perf_miss_cnt      (perf_miss_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // memory keyed by word address; cache model: per set, line addresses MRU first
  logic [31:0] mem [logic [29:0]];
  logic [29:0] sets_q [64][$];
  int exp_hits = 0;
  int exp_miss = 0;

  function automatic logic [31:0] get_word(input logic [29:0] k);
    if (!mem.exists(k)) mem[k] = $urandom;
    return mem[k];
  endfunction

  function automatic int find_line(input logic [31:0] a);
    int s;
    s = int'(a[7:2]);
    for (int i = 0; i < sets_q[s].size(); i++)
      if (sets_q[s][i] == a[31:2]) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) sets_q[s].delete();
    exp_hits = 0;
    exp_miss = 0;
  endfunction

  function automatic logic [31:0] apply_write(input logic [31:0] old,
      input logic [1:0] size, input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] r;
    logic        sel;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (size == 2'd0)      sel = (b == int'(off));
      else if (size == 2'd1) sel = ((b / 2) == int'(off[1]));
      else                   sel = 1'b1;
      if (sel) r[8*b+:8] = wd[8*b+:8];
    end
    return r;
  endfunction

  task automatic access(input bit wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bit          cached, mhit, exp_mem, got_mem, got_dok;
    int          ph, wt, lat, pos, s;
    logic [31:0] rd_seen, m_addr, m_wdata, exp_rd;
    logic [1:0]  m_size;
    logic        m_wr;
    cached  = addr[31:29] != 3'b101;
    pos     = cached ? find_line(addr) : -1;
    mhit    = pos >= 0;
    exp_mem = !cached || wr || !mhit;
    exp_rd  = get_word(addr[31:2]);
    got_mem = 0; got_dok = 0; ph = 0; wt = 0; lat = 0;
    rd_seen = '0; m_addr = '0; m_wdata = '0; m_size = '0; m_wr = 0;
    @(negedge clk);
    cpu_data_req   = 1'b1;
    cpu_data_wr    = wr;
    cpu_data_size  = size;
    cpu_data_addr  = addr;
    cpu_data_wdata = wdata;
    #1 chk("addr_ok", cpu_data_addr_ok, 1);
    @(posedge clk);
    #1 cpu_data_req = 1'b0;
    for (int c = 1; c <= 40 && !got_dok; c++) begin
      @(negedge clk);
      cache_data_addr_ok = 1'b0;
      cache_data_data_ok = 1'b0;
      cache_data_rdata   = $urandom;
      if (ph == 0 && cache_data_req) begin
        got_mem = 1;
        m_wr    = cache_data_wr;
        m_size  = cache_data_size;
        m_addr  = cache_data_addr;
        m_wdata = cache_data_wdata;
        ph      = 1;
        wt      = $urandom_range(0, 2);
      end
      if (ph == 1) begin
        if (wt == 0) begin
          cache_data_addr_ok = 1'b1;
          ph = 3;
          wt = $urandom_range(0, 2);
        end else begin
          wt--;
          cache_data_data_ok = 1'($urandom_range(0, 1));
        end
      end else if (ph == 2) begin
        if (wt == 0) begin
          cache_data_data_ok = 1'b1;
          if (!wr) cache_data_rdata = get_word(addr[31:2]);
        end else begin
          wt--;
          cache_data_addr_ok = 1'($urandom_range(0, 1));
        end
      end
      #1;
      if (cpu_data_data_ok) begin
        got_dok = 1;
        lat     = c;
        rd_seen = cpu_data_rdata;
      end
      if (ph == 3) ph = 2;
    end
    @(posedge clk);
    #1;
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    chk("data_ok_seen", got_dok, 1);
    chk("mem_req_issued", got_mem, exp_mem);
    if (!wr) chk("rdata", rd_seen, exp_rd);
    if (!exp_mem) chk("hit_latency", lat, 1);
    if (got_mem && exp_mem) begin
      chk("mem_wr", m_wr, wr);
      chk("mem_size", m_size, (cached && !wr) ? 2'd2 : size);
      chk("mem_addr", m_addr, (cached && !wr) ? {addr[31:2], 2'b00} : addr);
      if (wr) chk("mem_wdata", m_wdata, wdata);
    end
    if (wr) mem[addr[31:2]] = apply_write(exp_rd, size, addr[1:0], wdata);
    if (cached) begin
      s = int'(addr[7:2]);
      if (mhit) begin
        exp_hits++;
        sets_q[s].delete(pos);
        sets_q[s].push_front(addr[31:2]);
      end else begin
        exp_miss++;
        if (!wr) begin
          sets_q[s].push_front(addr[31:2]);
          if (sets_q[s].size() > 2) void'(sets_q[s].pop_back());
        end
      end
    end
  endtask

  task automatic rd(input logic [31:0] a);
    access(1'b0, 2'd2, a, 32'h0);
  endtask

  task automatic reset_in_mem_data();
    bit seen;
    seen = 0;
    @(negedge clk);
    cpu_data_req  = 1'b1;
    cpu_data_wr   = 1'b0;
    cpu_data_size = 2'd2;
    cpu_data_addr = 32'h0000_0300;
    @(posedge clk);
    #1 cpu_data_req = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (cache_data_req) seen = 1;
    end
    chk("rst_mem_req_seen", seen, 1);
    cache_data_addr_ok = 1'b1;
    @(posedge clk);
    #1 cache_data_addr_ok = 1'b0;
    @(negedge clk);
    rst          = 1'b0;
    cpu_data_req = 1'b1;
    #1;
    chk("rst_mid_addr_ok", cpu_data_addr_ok, 0);
    chk("rst_mid_data_ok", cpu_data_data_ok, 0);
    chk("rst_mid_mem_req", cache_data_req, 0);
    @(negedge clk);
    rst                = 1'b1;
    cpu_data_req       = 1'b0;
    cache_data_data_ok = 1'b1;
    cache_data_rdata   = 32'hDEAD_BEEF;
    #1 chk("rst_late_data_ok", cpu_data_data_ok, 0);
    @(posedge clk);
    #1 cache_data_data_ok = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    rst                = 1'b0;
    cpu_data_req       = 1'b1;
    cpu_data_wr        = 1'b0;
    cpu_data_size      = 2'd2;
    cpu_data_addr      = 32'h40;
    cpu_data_wdata     = '0;
    cache_data_rdata   = 32'h5555_AAAA;
    cache_data_addr_ok = 1'b1;
    cache_data_data_ok = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_ok", cpu_data_addr_ok, 0);
    chk("rst_data_ok", cpu_data_data_ok, 0);
    chk("rst_rdata", cpu_data_rdata, 0);
    chk("rst_mem_req", cache_data_req, 0);
    chk("rst_mem_addr", cache_data_addr, 0);
    cpu_data_req       = 1'b0;
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    rst                = 1'b1;

    mem[30'h10] = 32'h1234_5678;
    rd(32'h0000_0040);
    rd(32'h0000_0040);
`ifdef DCACHE_PERF_EN
    chk("perf_hit", perf_hit_cnt, 1);
    chk("perf_miss", perf_miss_cnt, 1);
`endif
    access(1'b1, 2'd0, 32'h0000_0041, 32'hABAB_ABAB);
    chk("byte_merge_model", mem[30'h10], 32'h1234_AB78);
    rd(32'h0000_0040);

    rd(32'h0000_0000);
    rd(32'h0000_0100);
    rd(32'h0000_0000);
    rd(32'h0000_0200);
    rd(32'h0000_0000);
    rd(32'h0000_0100);

    rd(32'hA000_0040);
    rd(32'hA000_0040);
    rd(32'h0000_0040);

    reset_in_mem_data();
    rd(32'h0000_0040);

    for (int n = 0; n < 300; n++) begin
      a  = {22'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 6'h0};
      a  = {a[31:8], 6'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 9) == 0) a[31:29] = 3'b101;
      sz = 2'($urandom_range(0, 2));
      if (sz == 2'd0) a[1:0] = 2'($urandom_range(0, 3));
      if (sz == 2'd1) a[1]   = 1'($urandom_range(0, 1));
      access($urandom_range(0, 9) < 4, sz, a, $urandom);
    end
`ifdef DCACHE_PERF_EN
    chk("perf_hit_end", perf_hit_cnt, exp_hits);
    chk("perf_miss_end", perf_miss_cnt, exp_miss);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_cache_assoc.md
D_CACHE_ASSOC -- requirements
Module: d_cache_assoc

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 6, meaning set-index bits, giving 2^INDEX_WIDTH sets.
REQ-002 SHALL have parameter WAYS, default 2, meaning associativity; legal values are 1 and 2.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cpu_data_req/cpu_data_wr  in  1/1  CPU request and write flag.
REQ-006 SHALL have ports cpu_data_size  in  2 and cpu_data_addr/cpu_data_wdata  in  32/32; size 0=byte, 1=half, 2=word.
REQ-007 SHALL have ports cpu_data_rdata  out  32 and cpu_data_addr_ok/cpu_data_data_ok  out  1/1.
REQ-008 SHALL have ports cache_data_req/cache_data_wr  out  1/1 and cache_data_size  out  2, forming the sram-like memory request.
REQ-009 SHALL have ports cache_data_addr/cache_data_wdata  out  32/32 and cache_data_rdata  in  32.
REQ-010 SHALL have ports cache_data_addr_ok/cache_data_data_ok  in  1/1, the memory handshake.

Function
REQ-011 SHALL split addresses as offset [1:0], index [INDEX_WIDTH+1:2] and tag [31:INDEX_WIDTH+2], with one 32-bit word per line.
REQ-012 SHALL implement FSM states IDLE, LOOKUP, MEM_ADDR and MEM_DATA.
REQ-013 SHALL assert cpu_data_addr_ok combinationally only when in IDLE with cpu_data_req=1, then latch req fields and go to LOOKUP.
REQ-014 SHALL allow at most one outstanding request, with addr_ok held 0 outside IDLE.
REQ-015 SHALL treat addr[31:29]=3'b101 as uncached, which bypasses lookup and does not modify arrays.
REQ-016 SHALL, in LOOKUP, on a cacheable read hit, assert cpu_data_data_ok with rdata=hit word and return to IDLE, giving 1 cycle after the addr_ok handshake.
REQ-017 SHALL, in LOOKUP, send a read miss, an uncached access or any write to MEM_ADDR.
REQ-018 SHALL, in LOOKUP, on a write hit, merge wdata bytes into the hit line per size/addr[1:0] (write-through); a write miss SHALL NOT allocate.
REQ-019 SHALL, in MEM_ADDR, hold cache_data_req=1 with latched fields until cache_data_addr_ok, then go to MEM_DATA.
REQ-020 SHALL, in MEM_ADDR on a cacheable read, issue size=2 with addr[1:0]=0; otherwise it SHALL forward CPU size/addr.
REQ-021 SHALL, in MEM_DATA on cache_data_data_ok, assert cpu_data_data_ok the same cycle with rdata=cache_data_rdata, then go to IDLE.
REQ-022 SHALL, on cache_data_data_ok for a cacheable read miss, refill the victim with tag and data and set it valid.
REQ-023 SHALL, for WAYS=2, pick the victim as the first invalid way (way0 first), else the per-set LRU way.
REQ-024 SHALL, for WAYS=2, on any hit or refill, mark the other way LRU.
REQ-025 SHALL ignore cache_data_data_ok outside MEM_DATA and cache_data_addr_ok outside MEM_ADDR.

Reset
REQ-026 SHALL, while rst=0, force the FSM to IDLE, clear all valid and LRU bits, and drive all outputs to 0 (rdata=0).
REQ-027 SHALL abandon an in-flight memory transaction when reset asserts mid-operation; no data_ok SHALL follow.
REQ-028 SHALL leave tag and data arrays unreset.

Configuration
REQ-029 SHALL, with DCACHE_PERF_EN defined, add outputs perf_hit_cnt  out  32 and perf_miss_cnt  out  32.
REQ-030 SHALL count cacheable LOOKUP hits and misses (reads and writes) in those counters, wrapping at 2^32 and reset to 0.
REQ-031 SHALL, without DCACHE_PERF_EN, omit the ports and counters, with otherwise identical behaviour.

Verification
REQ-032 SHALL cover: read 0x00000040 cold -> miss, mem req size=2 addr=0x00000040, data_ok with 0x12345678; repeat read -> data_ok 1 cycle after addr_ok, no mem req.
REQ-033 SHALL cover: after REQ-032, byte write 0xAB to 0x00000041 -> mem write size=0; read 0x00000040 hits returning 0x1234AB78.
REQ-034 SHALL cover: WAYS=2, INDEX_WIDTH=6, reads 0x0000, 0x0100, 0x0000, 0x0200 -> fourth evicts 0x0100; read 0x0000 still hits.
REQ-035 SHALL cover: read 0xA0000040 twice -> two mem reads with original size/addr, valid bits unchanged.
REQ-036 SHALL cover: rst low during MEM_DATA, then memory data_ok -> no cpu_data_data_ok, FSM IDLE, next read of 0x00000040 misses.
REQ-037 SHALL cover: with DCACHE_PERF_EN, REQ-032 sequence -> perf_hit_cnt=1, perf_miss_cnt=1.
